// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared types and constants for the multi-ported register
//                file: FSM state encoding, default geometry, and the helper
//                that derives the address width from the register count.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    // Sequencer states: CLEAR walks the array writing zeros, READY is normal
    // operation.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width for a file of nregs entries (nregs is a power of two).
    function automatic int rf_aw(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wr_arbiter
//  Description : Combinational write-port resolver for rf_multiport.
//                For every register it produces the winning write enable and
//                data (highest-index port wins), flags same-address
//                multi-port writes, and produces the bypass hit/data seen by
//                each read port.
//  Ports       : en        - writes are allowed this cycle
//                we/waddr/wdata - NWR write requests
//                raddr     - NRD read addresses (for bypass matching)
//                reg_we/reg_wdata - per-register resolved write
//                collision - two or more enabled ports hit one non-zero addr
//                byp_hit/byp_data - per-read-port bypass result
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_arbiter #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = 5
) (
    input  logic                           en,
    input  logic [NWR-1:0]                 we,
    input  logic [NWR-1:0][AW-1:0]         waddr,
    input  logic [NWR-1:0][XLEN-1:0]       wdata,
    input  logic [NRD-1:0][AW-1:0]         raddr,
    output logic [NREGS-1:1]               reg_we,
    output logic [NREGS-1:1][XLEN-1:0]     reg_wdata,
    output logic                           collision,
    output logic [NRD-1:0]                 byp_hit,
    output logic [NRD-1:0][XLEN-1:0]       byp_data
);

    // A port request is live only when writes are allowed, it is enabled,
    // and it does not target x0.
    logic [NWR-1:0] w_live;

    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            w_live[p] = en && we[p] && (waddr[p] != '0);
        end
    end

    // Per-register decode. Ports are scanned in ascending order so a later
    // (higher-index) port overrides an earlier one on the same address.
    always_comb begin
        reg_we    = '0;
        reg_wdata = '0;
        for (int i = 1; i < NREGS; i++) begin
            for (int p = 0; p < NWR; p++) begin
                if (w_live[p] && (waddr[p] == AW'(i))) begin
                    reg_we[i]    = 1'b1;
                    reg_wdata[i] = wdata[p];
                end
            end
        end
    end

    // Any pair of live ports sharing an address is a collision.
    always_comb begin
        collision = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            for (int q = p + 1; q < NWR; q++) begin
                if (w_live[p] && w_live[q] && (waddr[p] == waddr[q])) begin
                    collision = 1'b1;
                end
            end
        end
    end

    // Bypass uses the same ascending scan so it forwards the same data that
    // will land in the array.
    always_comb begin
        byp_hit  = '0;
        byp_data = '0;
        for (int r = 0; r < NRD; r++) begin
            for (int p = 0; p < NWR; p++) begin
                if (w_live[p] && (waddr[p] == raddr[r])) begin
                    byp_hit[r]  = 1'b1;
                    byp_data[r] = wdata[p];
                end
            end
        end
    end

endmodule : rf_wr_arbiter
`default_nettype wire

// File: rtl/rf_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : rf_multiport
//  Description : Parametrised multi-ported integer register file with
//                write-to-read bypass, highest-port-wins write priority, a
//                registered write-collision pulse and a sequential hardware
//                clear run after reset or on request.
//  Ports       : clk          - clock, rising edge
//                rst          - asynchronous active-high reset
//                clear_req    - re-zero all registers (honoured in READY)
//                we/waddr/wdata - NWR write ports
//                raddr/rdata  - NRD combinational read ports
//                init_done    - file valid, writes accepted
//                wr_collision - previous cycle had a same-address write
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_multiport
    import rf_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRD    = 2,
    parameter  int NWR    = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = rf_aw(NREGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_req,
    input  logic [NWR-1:0]             we,
    input  logic [NWR-1:0][AW-1:0]     waddr,
    input  logic [NWR-1:0][XLEN-1:0]   wdata,
    input  logic [NRD-1:0][AW-1:0]     raddr,
    output logic [NRD-1:0][XLEN-1:0]   rdata,
    output logic                       init_done,
    output logic                       wr_collision
);

    localparam logic [AW-1:0] c_idx_first = AW'(1);
    localparam logic [AW-1:0] c_idx_last  = AW'(NREGS - 1);

    // x0 has no storage; it is hard-wired to zero on the read side.
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    rf_state_e       r_state;
    logic [AW-1:0]   r_idx;
    logic            r_init_done;
    logic            r_wr_collision;

    logic                        w_wr_en;
    logic [NREGS-1:1]            w_reg_we;
    logic [NREGS-1:1][XLEN-1:0]  w_reg_wdata;
    logic                        w_collision;
    logic [NRD-1:0]              w_byp_hit;
    logic [NRD-1:0][XLEN-1:0]    w_byp_data;

    // Writes on the edge that starts a clear are discarded, so they are
    // also kept out of bypass and collision detection.
    assign w_wr_en = (r_state == READY) && !clear_req;

    rf_wr_arbiter #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_arb (
        .en        (w_wr_en),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .reg_we    (w_reg_we),
        .reg_wdata (w_reg_wdata),
        .collision (w_collision),
        .byp_hit   (w_byp_hit),
        .byp_data  (w_byp_data)
    );

    // Clear sequencer. Starts at index 1 because x0 has no storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= CLEAR;
            r_idx          <= c_idx_first;
            r_init_done    <= 1'b0;
            r_wr_collision <= 1'b0;
        end else begin
            r_wr_collision <= w_collision;
            case (r_state)
                CLEAR: begin
                    if (r_idx == c_idx_last) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx + c_idx_first;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        r_state     <= CLEAR;
                        r_idx       <= c_idx_first;
                        r_init_done <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= CLEAR;
                    r_idx       <= c_idx_first;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the clear sequence is what zeroes it. r_idx is
    // never 0 while in CLEAR.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_regs[r_idx] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_reg_we[i]) begin
                    r_regs[i] <= w_reg_wdata[i];
                end
            end
        end
    end

    // Reads: zero for x0 and during clear, otherwise bypass or stored value.
    always_comb begin
        rdata = '0;
        for (int r = 0; r < NRD; r++) begin
            if ((r_state == READY) && (raddr[r] != '0)) begin
                if ((BYPASS != 0) && w_byp_hit[r]) begin
                    rdata[r] = w_byp_data[r];
                end else begin
                    rdata[r] = r_regs[raddr[r]];
                end
            end
        end
    end

    assign init_done    = r_init_done;
    assign wr_collision = r_wr_collision;

endmodule : rf_multiport
`default_nettype wire

// File: tb/tb_rf_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_multiport
//  Description : Self-checking bench for rf_multiport (NWR=2, NRD=2, with a
//                second BYPASS=0, NWR=1 instance sharing port 0 stimulus).
//                Directed steps plus a randomized phase, checked against an
//                abstract register-file model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_multiport;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      clear_req;
    logic [NWR-1:0]            we;
    logic [NWR-1:0][AW-1:0]    waddr;
    logic [NWR-1:0][XLEN-1:0]  wdata;
    logic [NRD-1:0][AW-1:0]    raddr;
    logic [NRD-1:0][XLEN-1:0]  rdata;
    logic [NRD-1:0][XLEN-1:0]  rdata_nb;
    logic                      init_done, wr_collision;
    logic                      init_done_nb, wr_collision_nb;

    int total = 0;
    int bad   = 0;

    // Abstract model: register contents, ready flag, clear edges remaining,
    // expected collision pulse.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_ready;
    int              m_left;
    bit              m_coll;

    always #5 clk = ~clk;

    rf_multiport #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata),
        .init_done(init_done), .wr_collision(wr_collision)
    );

    rf_multiport #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(1), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .we(we[0:0]), .waddr(waddr[0:0]), .wdata(wdata[0:0]),
        .raddr(raddr), .rdata(rdata_nb),
        .init_done(init_done_nb), .wr_collision(wr_collision_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_left  = NREGS - 1;
        m_coll  = 1'b0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    endtask

    // Expected read value for address a given the inputs now applied.
    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (a == '0 || !m_ready) return '0;
        v = m_regs[a];
        if (!clear_req)
            for (int p = 0; p < NWR; p++)
                if (we[p] && waddr[p] == a) v = wdata[p];
        return v;
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic model_edge();
        bit c;
        c = 1'b0;
        if (m_ready && clear_req) begin
            m_ready = 1'b0;
            m_left  = NREGS - 1;
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        end else if (m_ready) begin
            for (int p = 0; p < NWR; p++)
                if (we[p] && waddr[p] != '0) m_regs[waddr[p]] = wdata[p];
            for (int p = 0; p < NWR; p++)
                for (int q = p + 1; q < NWR; q++)
                    if (we[p] && we[q] && waddr[p] != '0 && waddr[p] == waddr[q]) c = 1'b1;
        end else begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end
        m_coll = c;
    endtask

    // Check combinational reads, clock one edge, check registered outputs.
    task automatic step(input string tag);
        #1;
        for (int r = 0; r < NRD; r++) chk({tag, "_rd"}, rdata[r], exp_rd(raddr[r]));
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, "_init"}, {31'b0, init_done}, {31'b0, m_ready});
        chk({tag, "_coll"}, {31'b0, wr_collision}, {31'b0, m_coll});
    endtask

    task automatic rand_inputs();
        for (int p = 0; p < NWR; p++) begin
            we[p]    = 1'($urandom_range(1));
            waddr[p] = AW'($urandom_range(7));
            wdata[p] = $urandom;
        end
        for (int r = 0; r < NRD; r++) raddr[r] = AW'($urandom_range(7));
    endtask

    initial begin
        rst = 1'b1; clear_req = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        raddr[0] = 5'd5;
        #1;
        chk("reset_init", {31'b0, init_done}, 32'd0);
        chk("reset_coll", {31'b0, wr_collision}, 32'd0);
        chk("reset_rd", rdata[0], 32'd0);
        rst = 1'b0;

        // Reset release: 31 clearing edges.
        for (int e = 1; e <= 31; e++) begin
            for (int r = 0; r < NRD; r++) raddr[r] = AW'($urandom_range(31));
            step("clr");
            if (e == 30) chk("clr_e30", {31'b0, init_done}, 32'd0);
        end
        chk("clr_e31", {31'b0, init_done}, 32'd1);
        chk("nb_init", {31'b0, init_done_nb}, 32'd1);
        for (int a = 0; a < NREGS; a += 3) begin
            raddr[0] = AW'(a);
            raddr[1] = AW'(NREGS - 1 - a);
            #1;
            chk("post_clr_rd0", rdata[0], 32'd0);
            chk("post_clr_rd1", rdata[1], 32'd0);
        end

        // Write then read, with and without bypass.
        we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF; raddr[0] = 5'd5; raddr[1] = 5'd0;
        #1;
        chk("byp_same", rdata[0], 32'hDEADBEEF);
        chk("nb_same_old", rdata_nb[0], 32'd0);
        step("wr5");
        we = '0;
        #1;
        chk("wr5_next", rdata[0], 32'hDEADBEEF);
        chk("nb_next", rdata_nb[0], 32'hDEADBEEF);
        step("wr5b");

        // Writes to x0 from both ports.
        we = 2'b11; waddr[0] = 5'd0; waddr[1] = 5'd0;
        wdata[0] = 32'hFFFFFFFF; wdata[1] = 32'hFFFFFFFF; raddr[0] = 5'd0; raddr[1] = 5'd0;
        #1;
        chk("x0_same", rdata[0], 32'd0);
        step("x0");
        we = '0;
        #1;
        chk("x0_next", rdata[0], 32'd0);
        chk("x0_coll", {31'b0, wr_collision}, 32'd0);

        // Same-address collision: port 1 wins.
        we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
        wdata[0] = 32'h11; wdata[1] = 32'h22; raddr[0] = 5'd7;
        #1;
        chk("coll_byp", rdata[0], 32'h22);
        step("coll");
        chk("coll_set", {31'b0, wr_collision}, 32'd1);
        we = '0;
        #1;
        chk("coll_reg7", rdata[0], 32'h22);
        step("coll_b");
        chk("coll_clr", {31'b0, wr_collision}, 32'd0);
        chk("nb_coll", {31'b0, wr_collision_nb}, 32'd0);

        // Randomized traffic on a small address window to provoke collisions.
        repeat (200) begin
            rand_inputs();
            step("rnd");
        end

        // Clear request with a simultaneous (dropped) write.
        we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'hA5;
        step("pre_clr");
        waddr[0] = 5'd4; wdata[0] = 32'h5A; clear_req = 1'b1; raddr[0] = 5'd3; raddr[1] = 5'd4;
        step("creq");
        chk("creq_init", {31'b0, init_done}, 32'd0);
        clear_req = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            rand_inputs();
            step("cclr");
            if (e == 30) chk("cclr_e30", {31'b0, init_done}, 32'd0);
        end
        chk("cclr_done", {31'b0, init_done}, 32'd1);
        we = '0; raddr[0] = 5'd3; raddr[1] = 5'd4;
        #1;
        chk("cclr_reg3", rdata[0], 32'd0);
        chk("cclr_reg4", rdata[1], 32'd0);

        // Reset pulse in the middle of a clear (idx = 10).
        clear_req = 1'b1;
        step("rclr_req");
        clear_req = 1'b0;
        repeat (9) step("rclr_mid");
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_init", {31'b0, init_done}, 32'd0);
        chk("rst_coll", {31'b0, wr_collision}, 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            for (int r = 0; r < NRD; r++) raddr[r] = AW'($urandom_range(31));
            step("rclr");
            if (e == 30) chk("rclr_e30", {31'b0, init_done}, 32'd0);
        end
        chk("rclr_done", {31'b0, init_done}, 32'd1);

        // A few more random cycles after the restart.
        repeat (40) begin
            rand_inputs();
            step("rnd2");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rf_multiport
`default_nettype wire
